// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Build option RD_STREAM_STATS_EN (in the top) adds transfer/stall counters.
package fifo_pkg;

   localparam int FIFO_DATA_W = 32;
   localparam int STAT_W      = 32;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for the adapter.
// master = adapter side, slave = FIFO / downstream consumer side.
interface fifo_rd_stream_adapter_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W
);

   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_ren;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      input  fifo_dout, fifo_empty, m_ready,
      output fifo_ren, m_data, m_valid, m_last
   );

   modport slave (
      output fifo_dout, fifo_empty, m_ready,
      input  fifo_ren, m_data, m_valid, m_last
   );

endinterface

// File: rtl/fifo_skid_buf2.sv
// Two-entry in-order buffer. ent0 is always the head; clear beats push/pop.
// Only data is stored; the burst-last flag is derived by the consumer.
module fifo_skid_buf2
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [1:0]            occ
);

   logic [DATA_WIDTH-1:0] ent0;
   logic [DATA_WIDTH-1:0] ent1;

   assign dout = ent0;

   // Occupancy: push and pop together leave it unchanged.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         occ <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Entry moves: pop shifts ent1 to head; push lands behind the surviving entries.
   always_ff @(posedge clk) begin
      if (pop) begin
         ent0 <= ent1;
         if (push) begin
            if (occ == 2'd1) ent0 <= din;
            else             ent1 <= din;
         end
      end else if (push) begin
         if (occ == 2'd0) ent0 <= din;
         else             ent1 <= din;
      end
   end

   // The read credit logic upstream must never let a third word land.
   assert property (@(posedge clk) disable iff (rst || clear)
                    !(push && !pop && occ == 2'd2));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream framed
// into BURST_LEN-word bursts. Optional macro RD_STREAM_STATS_EN adds
// saturating words_out / stall_cnt counters.
module fifo_rd_stream_adapter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W,
   parameter int BURST_LEN  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   fifo_rd_stream_adapter_if.master bus,
   input  logic                     flush,
   output logic                     busy
`ifdef RD_STREAM_STATS_EN
   ,
   output logic [STAT_W-1:0]        words_out,
   output logic [STAT_W-1:0]        stall_cnt
`endif
);

   localparam int BCNT_W = $clog2(BURST_LEN) + 1;

   state_t                state;
   state_t                state_nxt;
   logic                  inflight;
   logic [1:0]            occ;
   logic [BCNT_W-1:0]     bcnt;
   logic [DATA_WIDTH-1:0] head;
   logic                  run;
   logic                  pop;
   logic                  xfer;
   logic                  clear;
   logic                  credit;

   assign run = (state == RUN);

   // A word popped this cycle frees its slot in time for a read issued now,
   // which is what allows one word per clock with only two entries.
   assign credit = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

   assign bus.fifo_ren = ~rst & run & ~bus.fifo_empty & credit;
   assign bus.m_valid  = run & (occ != 2'd0);
   assign bus.m_data   = head;
   assign bus.m_last   = bus.m_valid & (bcnt == BCNT_W'(BURST_LEN - 1));

   assign pop   = bus.m_valid & bus.m_ready;
   assign xfer  = pop & ~flush;
   assign clear = flush | ~run;
   assign busy  = (occ != 2'd0) | inflight | ~run;

   fifo_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (inflight),
      .pop   (pop),
      .din   (bus.fifo_dout),
      .dout  (head),
      .occ   (occ)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next state: FLUSH lasts until the last outstanding read has landed.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = FLUSH;
         FLUSH:   if (!inflight && !flush) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // A read issued this cycle returns data next cycle.
   always_ff @(posedge clk) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= bus.fifo_ren;
   end

   // Burst position of the head word; restarts on flush.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         bcnt <= '0;
      end else if (xfer) begin
         if (bus.m_last) bcnt <= '0;
         else            bcnt <= bcnt + BCNT_W'(1);
      end
   end

`ifdef RD_STREAM_STATS_EN
   // Saturating transfer and stall counters; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         words_out <= '0;
         stall_cnt <= '0;
      end else begin
         if (xfer && (words_out != '1))
            words_out <= words_out + STAT_W'(1);
         if (bus.m_valid && !bus.m_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter: stimulus queues expected
// {last,data} words, an independent monitor pops and compares on transfers.
module tb_fifo_rd_stream_adapter;

   localparam int DW = 32;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic flush = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef RD_STREAM_STATS_EN
   logic [31:0] words_out;
   logic [31:0] stall_cnt;
`endif

   fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .flush     (flush),
      .busy      (busy)
`ifdef RD_STREAM_STATS_EN
      ,
      .words_out (words_out),
      .stall_cnt (stall_cnt)
`endif
   );

   // Synchronous FIFO model with registered read data.
   logic [DW-1:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;

   assign bus.fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (rst) rd_ptr <= 0;
      else if (bus.fifo_ren) begin
         bus.fifo_dout <= mem[rd_ptr[7:0]];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW:0]   exp_q [$];
   logic          chk_credit = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Monitor: scoreboard pops, stall stability, read credit.
   initial begin
      logic        xfer;
      logic        prev_stall;
      logic [DW:0] prev_word;
      logic [DW:0] e;
      int          issued;
      int          accepted;
      int          outst;
      prev_stall = 1'b0;
      prev_word  = '0;
      issued     = 0;
      accepted   = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            issued     = 0;
            accepted   = 0;
         end else begin
            xfer = bus.m_valid && bus.m_ready && !flush;
            if (prev_stall) begin
               check("stall_valid_held", 64'(bus.m_valid), 64'd1);
               check("stall_word_held", 64'({bus.m_last, bus.m_data}), 64'(prev_word));
            end
            if (chk_credit && bus.fifo_ren) begin
               outst = issued - accepted - (xfer ? 1 : 0);
               check("ren_with_no_credit", 64'(outst < 2), 64'd1);
            end
            if (xfer) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_word actual=%0h required=none", {bus.m_last, bus.m_data});
               end else begin
                  e = exp_q.pop_front();
                  check("stream_word", 64'({bus.m_last, bus.m_data}), 64'(e));
               end
            end
            prev_stall = bus.m_valid && !bus.m_ready && !flush;
            prev_word  = {bus.m_last, bus.m_data};
            if (bus.fifo_ren) issued++;
            if (xfer) accepted++;
         end
      end
   end

   task automatic wait_drain(input string name, input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic reset_load(input logic [DW-1:0] base, input int n);
      @(posedge clk); #1;
      rst         = 1'b1;
      flush       = 1'b0;
      bus.m_ready = 1'b1;
      for (int i = 0; i < n; i++) mem[i] = base + DW'(i);
      wr_ptr = n;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic void push_exp(input logic [DW-1:0] base, input int first, input int n, input int pos0);
      for (int i = 0; i < n; i++)
         exp_q.push_back({((pos0 + i) % 16) == 15, base + DW'(first + i)});
   endfunction

   initial begin
      int n;
      int lat;
      int cyc;
      int rens;
      int stalls;
      bus.m_ready = 1'b1;

      // Reset held with a non-empty FIFO: nothing may move.
      for (int i = 0; i < 40; i++) mem[i] = DW'(i);
      wr_ptr = 40;
      repeat (3) begin
         @(negedge clk);
         check("rst_fifo_ren", 64'(bus.fifo_ren), 64'd0);
         check("rst_m_valid", 64'(bus.m_valid), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
      end

      // Streaming 0..39 at full rate, last on words 15 and 31.
      push_exp('0, 0, 40, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.fifo_ren && n < 10) begin @(negedge clk); n++; end
      check("first_ren_seen", 64'(bus.fifo_ren), 64'd1);
      lat = 0;
      while (!bus.m_valid && lat < 10) begin @(negedge clk); lat++; end
      check("first_valid_latency", 64'(lat), 64'd2);
      #1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin @(negedge clk); #1; cyc++; end
      check("stream_b2b_cycles", 64'(cyc), 64'd39);
      wait_drain("stream_drain", 10);

      // Random backpressure over 100 words.
      reset_load(32'hA000, 100);
      push_exp(32'hA000, 0, 100, 0);
      chk_credit = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk); #1;
         bus.m_ready = 1'($urandom_range(0, 1));
         n++;
      end
      @(posedge clk); #1;
      chk_credit  = 1'b0;
      bus.m_ready = 1'b1;
      wait_drain("bp_drain", 10);

      // Single-word FIFO: one read, word delivered, then idle.
      reset_load(32'h400, 1);
      push_exp(32'h400, 0, 1, 0);
      rens = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.fifo_ren) rens++;
      end
      check("one_word_ren_count", 64'(rens), 64'd1);
      check("one_word_busy_idle", 64'(busy), 64'd0);
      wait_drain("one_word_drain", 10);

      // Flush with word 5 at the head: 5,6,7 dropped, 8 restarts a burst.
      reset_load(32'h500, 40);
      push_exp(32'h500, 0, 5, 0);
      push_exp(32'h500, 8, 32, 0);
      n = 0;
      @(posedge clk); #1;
      while (!(bus.m_valid && bus.m_data == 32'h505) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("flush_head_word5", 64'(bus.m_data), 64'h505);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_m_valid_low", 64'(bus.m_valid), 64'd0);
      check("flush_busy", 64'(busy), 64'd1);
      wait_drain("flush_drain", 200);

`ifdef RD_STREAM_STATS_EN
      // Stats: 20 words, exactly 7 stall cycles.
      reset_load(32'h600, 20);
      push_exp(32'h600, 0, 20, 0);
      stalls = 0;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
         if (bus.m_valid && stalls < 7 && (n % 2 == 1)) begin
            bus.m_ready = 1'b0;
            stalls++;
         end else begin
            bus.m_ready = 1'b1;
         end
      end
      bus.m_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("stats_words_out", 64'(words_out), 64'd20);
      check("stats_stall_cnt", 64'(stall_cnt), 64'd7);
      wait_drain("stats_drain", 10);
`else
      stalls = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
